// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS main controller and its datapath:
// instruction fields and ALU flag in, ALU code and datapath enables/selects out.
interface multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         Op;
    logic [5:0]         Funct;
    logic               Zero;
    logic [3:0]         AluCtrlOut;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               PCEn;
    logic [1:0]         PCSource;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic               ExtOp;
    logic               Illegal;
    logic [STATE_W-1:0] State;

    modport master (
        input  Op, Funct, Zero,
        output AluCtrlOut, PCWrite, PCWriteCond, PCEn, PCSource, IorD,
               MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst,
               ALUSrcA, ALUSrcB, ExtOp, Illegal, State
    );

    modport slave (
        output Op, Funct, Zero,
        input  AluCtrlOut, PCWrite, PCWriteCond, PCEn, PCSource, IorD,
               MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst,
               ALUSrcA, ALUSrcB, ExtOp, Illegal, State
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with ALU code decoded from opcode and funct.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_LUI = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 0,
        DECODE = 1,
        MEMADR = 2,
        MEMRD  = 3,
        MEMWB  = 4,
        MEMWR  = 5,
        RTEXE  = 6,
        RTWB   = 7,
        BRANCH = 8,
        IEXE   = 9,
        IWB    = 10,
        JUMP   = 11
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] rt_code;
    logic       rt_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FETCH;
        else        state <= next_state;
    end

    // Funct decode for R-type; an unsupported funct makes the instruction illegal.
    always_comb begin
        rt_code = ALU_ADD;
        rt_ok   = 1'b1;
        case (bus.Funct)
            6'b100000: rt_code = ALU_ADD;
            6'b100010: rt_code = ALU_SUB;
            6'b100100: rt_code = ALU_AND;
            6'b100101: rt_code = ALU_OR;
            6'b100110: rt_code = ALU_XOR;
            6'b101010: rt_code = ALU_SLT;
            default:   rt_ok   = 1'b0;
        endcase
    end

    always_comb begin
        next_state      = FETCH;
        bus.AluCtrlOut  = ALU_ADD;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCSource    = 2'b00;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ExtOp       = 1'b0;
        bus.Illegal     = 1'b0;

        case (state)
            FETCH: begin
                next_state   = DECODE;
                bus.MemRead  = 1'b1;
                bus.IRWrite  = 1'b1;
                bus.PCWrite  = 1'b1;
                bus.ALUSrcB  = 2'b01;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.ExtOp   = 1'b1;
                case (bus.Op)
                    OP_LW, OP_SW:            next_state = MEMADR;
                    OP_BEQ:                  next_state = BRANCH;
                    OP_ADDI, OP_ORI, OP_LUI: next_state = IEXE;
                    OP_J:                    next_state = JUMP;
                    OP_RTYPE: begin
                        if (rt_ok) next_state  = RTEXE;
                        else       bus.Illegal = 1'b1;
                    end
                    default:                 bus.Illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                next_state  = (bus.Op == OP_LW) ? MEMRD : MEMWR;
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ExtOp   = 1'b1;
            end
            MEMRD: begin
                next_state  = MEMWB;
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            RTEXE: begin
                next_state     = RTWB;
                bus.ALUSrcA    = 1'b1;
                bus.AluCtrlOut = rt_code;
            end
            RTWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.AluCtrlOut  = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
            end
            IEXE: begin
                next_state  = IWB;
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                case (bus.Op)
                    OP_ADDI: begin
                        bus.AluCtrlOut = ALU_ADD;
                        bus.ExtOp      = 1'b1;
                    end
                    OP_ORI:  bus.AluCtrlOut = ALU_OR;
                    OP_LUI:  bus.AluCtrlOut = ALU_LUI;
                    default: bus.AluCtrlOut = ALU_ADD;
                endcase
            end
            IWB: begin
                bus.RegWrite = 1'b1;
            end
            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            default: begin
                bus.AluCtrlOut = 4'b0000;
            end
        endcase

        // In reset the datapath sees FETCH selects but no enable is allowed through.
        if (!rst_n) begin
            bus.AluCtrlOut  = ALU_ADD;
            bus.PCWrite     = 1'b0;
            bus.PCWriteCond = 1'b0;
            bus.PCSource    = 2'b00;
            bus.IorD        = 1'b0;
            bus.MemRead     = 1'b0;
            bus.MemWrite    = 1'b0;
            bus.IRWrite     = 1'b0;
            bus.RegWrite    = 1'b0;
            bus.MemtoReg    = 1'b0;
            bus.RegDst      = 1'b0;
            bus.ALUSrcA     = 1'b0;
            bus.ALUSrcB     = 2'b01;
            bus.ExtOp       = 1'b0;
            bus.Illegal     = 1'b0;
        end
    end

    assign bus.PCEn  = bus.PCWrite | (bus.PCWriteCond & bus.Zero);
    assign bus.State = rst_n ? state : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its state sequence and checks hand-computed control outputs.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;
    logic regWriteSeen;

    multicycle_ctrl_if #(.STATE_W(4)) bus ();

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct, input logic zero);
        bus.Op    = op;
        bus.Funct = funct;
        bus.Zero  = zero;
    endtask

    task automatic stepState(input string tag, input int exp);
        @(negedge clk);
        checkOutput(tag, 32'(bus.State), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(6'b000000, 6'b000000, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_state", 32'(bus.State), 0);
        checkOutput("rst_enables", 32'({bus.PCWrite, bus.PCWriteCond, bus.PCEn, bus.MemRead,
                    bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.Illegal}), 0);
        checkOutput("rst_alu", 32'(bus.AluCtrlOut), 32'h2);
        checkOutput("rst_srcb", 32'(bus.ALUSrcB), 1);

        rst_n = 1'b1;
        applyStimulus(6'b100011, 6'b000000, 1'b0);
        #1;
        checkOutput("fetch_state", 32'(bus.State), 0);
        checkOutput("fetch_enables", 32'({bus.MemRead, bus.IRWrite, bus.PCWrite}), 32'h7);
        checkOutput("fetch_alu", 32'(bus.AluCtrlOut), 32'h2);

        stepState("lw_decode", 1);
        stepState("lw_memadr", 2);
        checkOutput("lw_memadr_srcb", 32'({bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp}), 32'b1101);
        stepState("lw_memrd", 3);
        checkOutput("lw_memrd_iord", 32'({bus.IorD, bus.MemRead}), 32'b11);
        stepState("lw_memwb", 4);
        checkOutput("lw_memwb_wr", 32'({bus.RegWrite, bus.MemtoReg, bus.RegDst}), 32'b110);
        stepState("lw_fetch", 0);

        applyStimulus(6'b101011, 6'b000000, 1'b0);
        stepState("sw_decode", 1);
        stepState("sw_memadr", 2);
        stepState("sw_memwr", 5);
        checkOutput("sw_memwr_en", 32'({bus.MemWrite, bus.IorD, bus.MemRead}), 32'b110);
        stepState("sw_fetch", 0);

        applyStimulus(6'b000000, 6'b100110, 1'b0);
        stepState("xor_decode", 1);
        stepState("xor_rtexe", 6);
        checkOutput("xor_alu", 32'(bus.AluCtrlOut), 32'h3);
        stepState("xor_rtwb", 7);
        checkOutput("xor_rtwb_dst", 32'({bus.RegWrite, bus.RegDst, bus.MemtoReg}), 32'b110);
        stepState("xor_fetch", 0);

        applyStimulus(6'b000000, 6'b101010, 1'b0);
        stepState("slt_decode", 1);
        stepState("slt_rtexe", 6);
        checkOutput("slt_alu", 32'(bus.AluCtrlOut), 32'h7);
        stepState("slt_rtwb", 7);
        stepState("slt_fetch", 0);

        applyStimulus(6'b000100, 6'b000000, 1'b1);
        stepState("beq1_decode", 1);
        stepState("beq1_branch", 8);
        checkOutput("beq1_pcen", 32'(bus.PCEn), 1);
        checkOutput("beq1_pcsrc", 32'(bus.PCSource), 1);
        checkOutput("beq1_alu", 32'(bus.AluCtrlOut), 32'h6);
        stepState("beq1_fetch", 0);

        applyStimulus(6'b000100, 6'b000000, 1'b0);
        stepState("beq0_decode", 1);
        stepState("beq0_branch", 8);
        checkOutput("beq0_pcen", 32'(bus.PCEn), 0);
        checkOutput("beq0_cond", 32'(bus.PCWriteCond), 1);
        stepState("beq0_fetch", 0);

        applyStimulus(6'b001101, 6'b000000, 1'b0);
        stepState("ori_decode", 1);
        stepState("ori_iexe", 9);
        checkOutput("ori_alu", 32'(bus.AluCtrlOut), 32'h1);
        checkOutput("ori_extop", 32'(bus.ExtOp), 0);
        stepState("ori_iwb", 10);
        checkOutput("ori_iwb_wr", 32'({bus.RegWrite, bus.RegDst, bus.MemtoReg}), 32'b100);
        stepState("ori_fetch", 0);

        applyStimulus(6'b001000, 6'b000000, 1'b0);
        stepState("addi_decode", 1);
        stepState("addi_iexe", 9);
        checkOutput("addi_alu_ext", 32'({bus.AluCtrlOut, bus.ExtOp}), 32'b00101);
        stepState("addi_iwb", 10);
        stepState("addi_fetch", 0);

        applyStimulus(6'b001111, 6'b000000, 1'b0);
        stepState("lui_decode", 1);
        stepState("lui_iexe", 9);
        checkOutput("lui_alu", 32'(bus.AluCtrlOut), 32'h4);
        stepState("lui_iwb", 10);
        stepState("lui_fetch", 0);

        applyStimulus(6'b000010, 6'b000000, 1'b0);
        stepState("j_decode", 1);
        stepState("j_jump", 11);
        checkOutput("j_pcwrite", 32'(bus.PCWrite), 1);
        checkOutput("j_pcsrc", 32'(bus.PCSource), 2);
        stepState("j_fetch", 0);

        applyStimulus(6'b111111, 6'b000000, 1'b0);
        stepState("ill_decode", 1);
        checkOutput("ill_flag", 32'(bus.Illegal), 1);
        stepState("ill_fetch", 0);
        checkOutput("ill_flag_clr", 32'(bus.Illegal), 0);

        applyStimulus(6'b000000, 6'b000001, 1'b0);
        stepState("badfn_decode", 1);
        checkOutput("badfn_flag", 32'(bus.Illegal), 1);
        stepState("badfn_fetch", 0);

        applyStimulus(6'b100011, 6'b000000, 1'b0);
        stepState("abort_decode", 1);
        stepState("abort_memadr", 2);
        stepState("abort_memrd", 3);
        rst_n = 1'b0;
        regWriteSeen = 1'b0;
        #1;
        regWriteSeen = regWriteSeen | bus.RegWrite;
        @(negedge clk);
        checkOutput("abort_state", 32'(bus.State), 0);
        regWriteSeen = regWriteSeen | bus.RegWrite;
        rst_n = 1'b1;
        applyStimulus(6'b111111, 6'b000000, 1'b0);
        #1;
        checkOutput("abort_refetch", 32'(bus.State), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            regWriteSeen = regWriteSeen | bus.RegWrite;
        end
        checkOutput("abort_no_regwrite", 32'(regWriteSeen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle MIPS main control unit. It drives the ALU's 4-bit operation code and every datapath enable, sequencing each instruction through fetch, decode, execute, memory and writeback states. It takes `Op` and `Funct` from the instruction register and `Zero` from the ALU. It sits between the IR/ALU and the multicycle datapath, replacing the single-cycle combinational control.

## Interface
Parameters:
- `STATE_W`, default 4: width of the state register and of the `State` debug port.

Ports:
- `clk  in  1`: sole clock; all state changes on the rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `Op  in  6`: IR[31:26]; valid from DECODE onward.
- `Funct  in  6`: IR[5:0].
- `Zero  in  1`: ALU zero flag.
- `AluCtrlOut  out  4`: ALU operation code.
  - ADD = 0010, SUB = 0110, AND = 0000, OR = 0001.
  - XOR = 0011, LUI = 0100, SLT = 0111.
- `PCWrite  out  1`: unconditional PC load.
- `PCWriteCond  out  1`: PC load if `Zero`.
- `PCEn  out  1`: `PCWrite | (PCWriteCond & Zero)`.
- `PCSource  out  2`: PC source select.
  - 00: ALU result.
  - 01: ALUOut register.
  - 10: jump target.
- `IorD  out  1`: memory address select (0 = PC, 1 = ALUOut).
- `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`  out  1 each: enables.
- `MemtoReg  out  1`: register write data select (1 = MDR).
- `RegDst  out  1`: destination register select (1 = rd, 0 = rt).
- `ALUSrcA  out  1`: ALU A select (0 = PC, 1 = A register).
- `ALUSrcB  out  2`: ALU B select.
  - 00: B register.
  - 01: constant 4.
  - 10: extended immediate.
  - 11: sign-extended immediate << 2.
- `ExtOp  out  1`: immediate extension (1 = sign-extend, 0 = zero-extend).
- `Illegal  out  1`: unsupported instruction flag.
- `State  out  STATE_W`: current state encoding.

## Operation
- Moore FSM. Outputs are a combinational decode of the state register, plus `Op`/`Funct` for `AluCtrlOut` and `ExtOp`.
- Any output not listed for a state is 0. Default `AluCtrlOut` is ADD.
- State encodings and per-state outputs:
  - FETCH (0): MemRead, IRWrite, PCWrite; IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ADD, PCSource = 00.
  - DECODE (1): ALUSrcA = 0, ALUSrcB = 11, ADD, ExtOp = 1 (branch target into ALUOut).
  - MEMADR (2): ALUSrcA = 1, ALUSrcB = 10, ExtOp = 1, ADD.
  - MEMRD (3): MemRead, IorD = 1.
  - MEMWB (4): RegWrite, MemtoReg = 1, RegDst = 0.
  - MEMWR (5): MemWrite, IorD = 1.
  - RTEXE (6): ALUSrcA = 1, ALUSrcB = 00; code from `Funct`.
    - 100000 → ADD, 100010 → SUB, 100100 → AND.
    - 100101 → OR, 100110 → XOR, 101010 → SLT.
  - RTWB (7): RegWrite, RegDst = 1, MemtoReg = 0.
  - BRANCH (8): ALUSrcA = 1, ALUSrcB = 00, SUB, PCWriteCond, PCSource = 01.
  - IEXE (9): ALUSrcA = 1, ALUSrcB = 10; by opcode:
    - addi (001000): ADD, ExtOp = 1.
    - ori (001101): OR, ExtOp = 0.
    - lui (001111): LUI.
  - IWB (10): RegWrite, RegDst = 0, MemtoReg = 0.
  - JUMP (11): PCWrite, PCSource = 10.
- Transitions:
  - FETCH → DECODE.
  - From DECODE by `Op`:
    - lw (100011) or sw (101011) → MEMADR.
    - R-type (000000) with a supported `Funct` → RTEXE.
    - beq (000100) → BRANCH.
    - addi, ori or lui → IEXE.
    - j (000010) → JUMP.
    - Anything else → FETCH, with `Illegal` high during that DECODE cycle. Unsupported R-type `Funct` counts as anything else.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB; RTEXE → RTWB; IEXE → IWB.
  - MEMWB, MEMWR, RTWB, IWB, BRANCH and JUMP → FETCH.
- Encodings 12–15 are unreachable; if entered, go to FETCH with all outputs 0.

## Timing
- Reset: `rst_n` sampled low at a rising edge loads FETCH.
  - While `rst_n` is low, all enables (PCWrite, PCWriteCond, PCEn, MemRead, MemWrite, IRWrite, RegWrite) and `Illegal` are forced to 0.
  - Selects and `AluCtrlOut` take their FETCH values; `State` = 0.
  - The first cycle with `rst_n` high is a real FETCH.
- Reset mid-instruction aborts it: the next state is FETCH and no partial writeback occurs afterwards.
- Cycles per instruction, counted from FETCH to the next FETCH:
  - lw 5; sw, R-type and I-type 4; beq and j 3; illegal 2.
- `PCEn` is combinational on `Zero` in BRANCH; the PC updates at the end of BRANCH only if `Zero` = 1.
- `Op`/`Funct` must stay stable from DECODE until the instruction returns to FETCH. `IRWrite` is asserted only in FETCH.

## Test plan
- Reset then release: `State` = 0.
  - During reset all enables are 0.
  - The first high cycle shows MemRead = IRWrite = PCWrite = 1 and `AluCtrlOut` = 0010.
- lw (Op = 100011): `State` sequence 0,1,2,3,4,0.
  - MEMRD has IorD = 1.
  - MEMWB has RegWrite = 1 and MemtoReg = 1.
- R-type xor (Funct = 100110): RTEXE shows `AluCtrlOut` = 0011; RTWB shows RegDst = 1.
  - Repeat for slt (101010): `AluCtrlOut` = 0111.
- beq: with `Zero` = 1, BRANCH shows PCEn = 1 and PCSource = 01. With `Zero` = 0, PCEn = 0. Both return to FETCH after 3 cycles.
- ori: IEXE shows `AluCtrlOut` = 0001 and ExtOp = 0.
  - lui: `AluCtrlOut` = 0100.
  - j: JUMP shows PCWrite = 1 and PCSource = 10.
- Op = 111111: DECODE asserts `Illegal`, then FETCH.
  - Drive `rst_n` low during MEMRD of a lw: the next state is 0 and RegWrite never asserts.
